// File: rtl/hazard_pkg.sv
// Shared types for the RV32 hazard controller: FSM state encoding and the
// E-stage forwarding-select codes used by hazard_fwd_sel and hazard_ctrl_unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding comparator for one E-stage source operand; the Memory-stage result
// takes priority over Writeback, and x0 is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          sel_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves it unassigned and infers a latch.
  always_comb begin
    sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage RV32 hazard controller: forwarding, load-use stall, branch flush and
// data-memory wait with sticky timeout. Define HAZARD_PERF_CNT_EN for perf counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic              mem_access_m,
  input  logic              mem_ready_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           mem_timeout_q, mem_timeout_d;
  logic           load_use, mem_wait, unused_reg_write_e;
  fwd_sel_t       fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i(rs1_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i(rs2_e), .rd_m_i(rd_m), .reg_write_m_i(reg_write_m),
    .rd_w_i(rd_w), .reg_write_w_i(reg_write_w), .sel_o(fwd_b)
  );

  // A load's destination is enough to flag load-use; reg_write_e adds nothing.
  assign unused_reg_write_e = reg_write_e;
  assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign mem_wait = (state_q == MEM_WAIT) ? !mem_ready_m : (mem_access_m && !mem_ready_m);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_access_m && !mem_ready_m) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready_m) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // Counts cycles spent in MEM_WAIT; the timeout flag rises with the count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d == RUN) begin
      wait_cnt_d = '0;
    end else if ((state_q == MEM_WAIT) && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    mem_timeout_d = mem_timeout_q || (wait_cnt_d == WAIT_MAX);
  end

  // Outputs are masked while reset is held so a mid-wait reset quiets them at once.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    forward_a_e = FWD_RF;
    forward_b_e = FWD_RF;
    if (rst) begin
      forward_a_e = fwd_a;
      forward_b_e = fwd_b;
      if (mem_wait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f || stall_d || stall_e || stall_m) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d || flush_e) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl_unit;

  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic reg_write_e, load_e, pc_src_e, reg_write_m, mem_access_m, mem_ready_m, reg_write_w;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
  logic [1:0] forward_a_e, forward_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_access_m(mem_access_m), .mem_ready_m(mem_ready_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,fwd_a[1:0],fwd_b[1:0]}
  logic [10:0] dut_ctrl;
  assign dut_ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                     forward_a_e, forward_b_e};

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: is an access outstanding from an earlier cycle, how
  // long has it been stuck, and how many stall/flush cycles have been seen.
  bit m_busy;
  int m_wait_cycles;
  bit m_timeout;
  int unsigned m_stalls, m_flushes;

  function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] exp_ctrl();
    logic [10:0] r;
    logic waiting, lu;
    r = '0;
    if (!rst) return r;
    waiting = !mem_ready_m && (m_busy || mem_access_m);
    lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    r[3:2] = exp_fwd(rs1_e);
    r[1:0] = exp_fwd(rs2_e);
    if (waiting) r[10:4] = 7'b1111001;
    else if (pc_src_e) r[10:4] = 7'b0000110;
    else if (lu) r[10:4] = 7'b1100010;
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [10:0] e;
    if (!rst) begin
      m_busy = 1'b0; m_wait_cycles = 0; m_timeout = 1'b0; m_stalls = 0; m_flushes = 0;
    end else begin
      e = exp_ctrl();
      if (|e[10:7]) m_stalls++;
      if (e[6] || e[5]) m_flushes++;
      if (!mem_ready_m && (m_busy || mem_access_m)) begin
        if (m_busy) m_wait_cycles++;
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
        m_wait_cycles = 0;
      end
      if (m_wait_cycles >= MAX_WAIT) m_timeout = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ctrl", dut_ctrl, exp_ctrl());
      check("mem_timeout", mem_timeout, m_timeout);
`ifdef HAZARD_PERF_CNT_EN
      check("stall_cnt", stall_cnt, CNT_W'(m_stalls));
      check("flush_cnt", flush_cnt, CNT_W'(m_flushes));
`else
      check("stall_cnt", stall_cnt, 0);
      check("flush_cnt", flush_cnt, 0);
`endif
    end
  end

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 0; load_e = 0; pc_src_e = 0; reg_write_m = 0;
    mem_access_m = 0; mem_ready_m = 0; reg_write_w = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_inputs();
    rs1_d = REG_AW'($urandom_range(0, 3)); rs2_d = REG_AW'($urandom_range(0, 3));
    rs1_e = REG_AW'($urandom_range(0, 3)); rs2_e = REG_AW'($urandom_range(0, 3));
    rd_e  = REG_AW'($urandom_range(0, 3)); rd_m  = REG_AW'($urandom_range(0, 3));
    rd_w  = REG_AW'($urandom_range(0, 3));
    reg_write_e  = 1'($urandom_range(0, 1));
    load_e       = ($urandom_range(0, 2) == 0);
    pc_src_e     = ($urandom_range(0, 4) == 0);
    reg_write_m  = 1'($urandom_range(0, 1));
    reg_write_w  = 1'($urandom_range(0, 1));
    mem_access_m = ($urandom_range(0, 3) == 0);
    mem_ready_m  = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    clear_inputs();
    // Reset held with inputs that would otherwise forward, stall and flush.
    rs1_e = 5; rd_m = 5; reg_write_m = 1; mem_access_m = 1; load_e = 1; rd_e = 3; rs1_d = 3;
    pc_src_e = 1;
    #3;
    check("reset_ctrl", dut_ctrl, 11'd0);
    check("reset_timeout", mem_timeout, 1'b0);
    check("reset_stall_cnt", stall_cnt, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Forwarding: M beats W, then W alone, x0 never forwarded.
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
    @(negedge clk);
    check("fwd_a_m_beats_w", forward_a_e, 2'b10);
    tick();
    rd_m = 0;
    @(negedge clk);
    check("fwd_a_w", forward_a_e, 2'b01);
    check("fwd_b_x0", forward_b_e, 2'b00);
    tick();

    // Load-use: one cycle of stall_f/stall_d/flush_e, then released.
    clear_inputs();
    load_e = 1; rd_e = 3; reg_write_e = 1; rs2_d = 3;
    @(negedge clk);
    check("load_use_stall", {stall_f, stall_d, flush_e, stall_e, stall_m, flush_d}, 6'b111000);
    tick();
    clear_inputs();
    rd_m = 3; reg_write_m = 1;
    @(negedge clk);
    check("load_use_release", dut_ctrl[10:4], 7'd0);
    tick();

    // Taken branch overrides a simultaneous load-use.
    clear_inputs();
    load_e = 1; rd_e = 3; rs1_d = 3; pc_src_e = 1;
    @(negedge clk);
    check("branch_over_load_use", {flush_d, flush_e, stall_f, stall_d}, 4'b1100);
    tick();

    // Four-cycle memory wait with a pending branch held back until ready.
    clear_inputs();
    mem_access_m = 1; pc_src_e = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mem_wait_stall", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d}, 6'b111110);
      tick();
    end
    mem_ready_m = 1;
    @(negedge clk);
    check("mem_ready_release", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d}, 6'b000001);
    tick();
    clear_inputs();
    @(negedge clk);
    check("back_to_run", dut_ctrl[10:4], 7'd0);
    tick();

    // Timeout: entry cycle plus MAX_WAIT cycles in the wait state.
    mem_access_m = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("timeout_rise", mem_timeout, (i >= MAX_WAIT + 1));
      tick();
    end
    mem_ready_m = 1;
    @(negedge clk);
    check("timeout_sticky_ready", mem_timeout, 1'b1);
    tick();
    clear_inputs();
    @(negedge clk);
    check("timeout_sticky_run", mem_timeout, 1'b1);
    tick();

    // Asynchronous reset in the middle of a wait.
    mem_access_m = 1; pc_src_e = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1;
    repeat (3) tick();
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_ctrl", dut_ctrl, 11'd0);
    check("async_rst_timeout", mem_timeout, 1'b0);
    check("async_rst_stall_cnt", stall_cnt, 0);
    check("async_rst_flush_cnt", flush_cnt, 0);
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      tick();
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
